// File: rtl/blockmem_arb_pkg.sv
// Shared constants and helpers for the two-client blockmem arbiter.
// The optional conflict statistics are enabled with BLOCKMEM_ARB_STATS_EN.
package blockmem_arb_pkg;

    localparam int NUM_CLIENTS = 2;
    localparam int CLIENT_API  = 0;
    localparam int CLIENT_CORE = 1;
    localparam int STATS_WIDTH = 16;

    // Saturating increment for the conflict counters
    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] v);
        logic [STATS_WIDTH-1:0] r;
        if (v == {STATS_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/blockmem_arb_if.sv
// Client-side request/ack bus plus blockmem-side port bundle of the arbiter.
// The arbiter uses the slave view; clients and the memory sit on the master view.
interface blockmem_arb_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic [1:0]      rd_req;
    logic [2*AW-1:0] rd_addr;
    logic [1:0]      rd_ack;
    logic [1:0]      rd_valid;
    logic [DW-1:0]   rd_data;
    logic [1:0]      wr_req;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]      wr_ack;
    logic [AW-1:0]   mem_read_addr;
    logic [DW-1:0]   mem_read_data;
    logic            mem_wr;
    logic [AW-1:0]   mem_write_addr;
    logic [DW-1:0]   mem_write_data;

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_read_data,
        output rd_ack, rd_valid, rd_data, wr_ack,
               mem_read_addr, mem_wr, mem_write_addr, mem_write_data
    );

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_read_data,
        input  rd_ack, rd_valid, rd_data, wr_ack,
               mem_read_addr, mem_wr, mem_write_addr, mem_write_data
    );
endinterface

// File: rtl/blockmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a lone requester wins, a contest goes to ~last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    // last=1 means client 1 won most recently, so client 0 has priority
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end
endmodule

// File: rtl/blockmem_arbiter.sv
// Shares one 256x32 blockmem between the API client (0) and the modexp core (1),
// arbitrating read and write ports independently. Stats: BLOCKMEM_ARB_STATS_EN.
module blockmem_arbiter
    import blockmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef BLOCKMEM_ARB_STATS_EN
    input  logic                   stats_clr,
    output logic [STATS_WIDTH-1:0] rd_conflicts,
    output logic [STATS_WIDTH-1:0] wr_conflicts,
`endif
    blockmem_arb_if.slave          bus
);
    logic [1:0]            rd_gnt_s, wr_gnt_s, rd_ack_s, wr_ack_s;
    logic                  rd_last_q, rd_last_d, wr_last_q, wr_last_d;
    logic [1:0]            rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s;

    rr_arb2 u_rd_arb (.req(bus.rd_req), .last(rd_last_q), .gnt(rd_gnt_s));
    rr_arb2 u_wr_arb (.req(bus.wr_req), .last(wr_last_q), .gnt(wr_gnt_s));

    // No grants while in reset, so nothing reaches the memory during reset
    assign rd_ack_s = rd_gnt_s & {2{reset_n}};
    assign wr_ack_s = wr_gnt_s & {2{reset_n}};

    // Next-state for last-winner, read address hold and read-valid pipeline
    always_comb begin
        rd_last_d  = rd_last_q;
        wr_last_d  = wr_last_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = rd_ack_s;
        if (|rd_ack_s) begin
            rd_last_d = rd_ack_s[CLIENT_CORE];
        end else begin
            rd_last_d = rd_last_q;
        end
        if (|wr_ack_s) begin
            wr_last_d = wr_ack_s[CLIENT_CORE];
        end else begin
            wr_last_d = wr_last_q;
        end
        if (rd_ack_s[CLIENT_CORE]) begin
            rd_addr_d = bus.rd_addr[CLIENT_CORE*ADDR_WIDTH +: ADDR_WIDTH];
        end else if (rd_ack_s[CLIENT_API]) begin
            rd_addr_d = bus.rd_addr[CLIENT_API*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
            rd_addr_d = rd_addr_q;
        end
    end

    // Write port mux from the granted client
    always_comb begin
        wr_addr_s = bus.wr_addr[CLIENT_API*ADDR_WIDTH +: ADDR_WIDTH];
        wr_data_s = bus.wr_data[CLIENT_API*DATA_WIDTH +: DATA_WIDTH];
        if (wr_ack_s[CLIENT_CORE]) begin
            wr_addr_s = bus.wr_addr[CLIENT_CORE*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_s = bus.wr_data[CLIENT_CORE*DATA_WIDTH +: DATA_WIDTH];
        end else begin
            wr_addr_s = bus.wr_addr[CLIENT_API*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_s = bus.wr_data[CLIENT_API*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Arbitration and read pipeline state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_last_q  <= 1'b1;
            wr_last_q  <= 1'b1;
            rd_valid_q <= 2'b00;
            rd_addr_q  <= {ADDR_WIDTH{1'b0}};
        end else begin
            rd_last_q  <= rd_last_d;
            wr_last_q  <= wr_last_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign bus.rd_ack         = rd_ack_s;
    assign bus.rd_valid       = rd_valid_q;
    assign bus.rd_data        = bus.mem_read_data;
    assign bus.mem_read_addr  = rd_addr_d;
    assign bus.wr_ack         = wr_ack_s;
    assign bus.mem_wr         = |wr_ack_s;
    assign bus.mem_write_addr = wr_addr_s;
    assign bus.mem_write_data = wr_data_s;

`ifdef BLOCKMEM_ARB_STATS_EN
    logic [STATS_WIDTH-1:0] rd_conf_q, rd_conf_d, wr_conf_q, wr_conf_d;

    // Contest counters; a clear pulse beats a same-cycle increment
    always_comb begin
        rd_conf_d = rd_conf_q;
        wr_conf_d = wr_conf_q;
        if (stats_clr) begin
            rd_conf_d = {STATS_WIDTH{1'b0}};
            wr_conf_d = {STATS_WIDTH{1'b0}};
        end else begin
            rd_conf_d = (bus.rd_req == 2'b11) ? sat_inc(rd_conf_q) : rd_conf_q;
            wr_conf_d = (bus.wr_req == 2'b11) ? sat_inc(wr_conf_q) : wr_conf_q;
        end
    end

    // Conflict counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_conf_q <= {STATS_WIDTH{1'b0}};
            wr_conf_q <= {STATS_WIDTH{1'b0}};
        end else begin
            rd_conf_q <= rd_conf_d;
            wr_conf_q <= wr_conf_d;
        end
    end

    assign rd_conflicts = rd_conf_q;
    assign wr_conflicts = wr_conf_q;
`endif
endmodule

// File: tb/tb_blockmem_arbiter.sv
// Directed bench for blockmem_arbiter with a behavioural 256x32 blockmem behind it.
// Stats checks are compiled in when BLOCKMEM_ARB_STATS_EN is defined.
module tb_blockmem_arbiter;
    logic clk;
    logic reset_n;
    int   checks;
    int   passes;

    blockmem_arb_if #(.AW(8), .DW(32)) bus ();

`ifdef BLOCKMEM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] rd_conflicts;
    logic [15:0] wr_conflicts;
`endif

    blockmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
`ifdef BLOCKMEM_ARB_STATS_EN
        .stats_clr    (stats_clr),
        .rd_conflicts (rd_conflicts),
        .wr_conflicts (wr_conflicts),
`endif
        .bus          (bus.slave)
    );

    // Blockmem: registered read, read-before-write on the same address
    logic [31:0] mem [256];
    always_ff @(posedge clk) begin
        if (bus.mem_wr) begin
            mem[bus.mem_write_addr] <= bus.mem_write_data;
        end
        bus.mem_read_data <= mem[bus.mem_read_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_rd(input int c, input logic [7:0] a);
        bus.rd_addr[c*8 +: 8] = a;
    endtask

    task automatic set_wr(input int c, input logic [7:0] a, input logic [31:0] d);
        bus.wr_addr[c*8 +: 8]  = a;
        bus.wr_data[c*32 +: 32] = d;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset_n = 1'b0;
        bus.rd_req  = 2'b00;
        bus.wr_req  = 2'b00;
        bus.rd_addr = 16'h0000;
        bus.wr_addr = 16'h0000;
        bus.wr_data = 64'h0;
`ifdef BLOCKMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        reset_n = 1'b1;

        // 1. idle after reset
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("idle_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
            chk("idle_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
            chk("idle_acks", {28'd0, bus.rd_ack, bus.wr_ack}, 32'd0);
        end

        // 2. c0 write 0xdeadbeef @0x10, then read it back
        set_wr(0, 8'h10, 32'hdeadbeef);
        bus.wr_req = 2'b01;
        #1;
        chk("wr_ack_c0", {30'd0, bus.wr_ack}, 32'd1);
        chk("mem_wr_c0", {31'd0, bus.mem_wr}, 32'd1);
        chk("mem_waddr_c0", {24'd0, bus.mem_write_addr}, 32'h10);
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;
        set_rd(0, 8'h10);
        bus.rd_req = 2'b01;
        #1;
        chk("wr_ack_one_cycle", {30'd0, bus.wr_ack}, 32'd0);
        chk("rd_ack_c0", {30'd0, bus.rd_ack}, 32'd1);
        chk("mem_raddr_c0", {24'd0, bus.mem_read_addr}, 32'h10);
        @(posedge clk);
        #1;
        bus.rd_req = 2'b00;
        chk("rd_valid_c0", {30'd0, bus.rd_valid}, 32'd1);
        chk("rd_data_c0", bus.rd_data, 32'hdeadbeef);

        // write contest: last write was c0, so c1 first, then c0
        set_wr(0, 8'h01, 32'ha1a1a1a1);
        set_wr(1, 8'h02, 32'hb2b2b2b2);
        bus.wr_req = 2'b11;
        #1;
        chk("wr_contest_1", {30'd0, bus.wr_ack}, 32'd2);
        @(posedge clk);
        #1;
        bus.wr_req = 2'b01;
        #1;
        chk("wr_contest_2", {30'd0, bus.wr_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;

        // c1 lone read so the next read contest starts with c0
        set_rd(1, 8'h02);
        bus.rd_req = 2'b10;
        #1;
        chk("rd_ack_c1", {30'd0, bus.rd_ack}, 32'd2);
        @(posedge clk);
        #1;
        chk("rd_data_c1", bus.rd_data, 32'hb2b2b2b2);

        // 3. both read every cycle
        set_rd(0, 8'h01);
        bus.rd_req = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_rd_ack", {30'd0, bus.rd_ack}, (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            chk("rr_rd_valid", {30'd0, bus.rd_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_rd_data", bus.rd_data, (k % 2 == 0) ? 32'ha1a1a1a1 : 32'hb2b2b2b2);
        end
        bus.rd_req = 2'b00;

        // 4. same-address read and write in one cycle returns the old word
        set_wr(0, 8'h20, 32'h0badf00d);
        bus.wr_req = 2'b01;
        #1;
        chk("wr_ack_0x20", {30'd0, bus.wr_ack}, 32'd1);
        @(posedge clk);
        #1;
        set_rd(0, 8'h20);
        set_wr(1, 8'h20, 32'h00000055);
        bus.rd_req = 2'b01;
        bus.wr_req = 2'b10;
        #1;
        chk("rbw_rd_ack", {30'd0, bus.rd_ack}, 32'd1);
        chk("rbw_wr_ack", {30'd0, bus.wr_ack}, 32'd2);
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;
        chk("rbw_old_data", bus.rd_data, 32'h0badf00d);
        #1;
        chk("rbw_rd_ack2", {30'd0, bus.rd_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus.rd_req = 2'b00;
        chk("rbw_new_data", bus.rd_data, 32'h00000055);

        // 5. reset pulse right after a read ack
        set_rd(0, 8'h01);
        bus.rd_req = 2'b01;
        #1;
        chk("pre_rst_rd_ack", {30'd0, bus.rd_ack}, 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.rd_req = 2'b00;
        set_wr(0, 8'h30, 32'h12345678);
        bus.wr_req = 2'b01;
        #1;
        chk("midrst_rd_valid", {30'd0, bus.rd_valid}, 32'd0);
        chk("midrst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_rd_valid2", {30'd0, bus.rd_valid}, 32'd0);
        reset_n = 1'b1;
        set_wr(1, 8'h31, 32'h87654321);
        bus.wr_req = 2'b11;
        bus.rd_req = 2'b11;
        set_rd(1, 8'h02);
        #1;
        chk("post_rst_rd_gnt", {30'd0, bus.rd_ack}, 32'd1);
        chk("post_rst_wr_gnt", {30'd0, bus.wr_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus.wr_req = 2'b00;
        bus.rd_req = 2'b00;
        chk("post_rst_rd_valid", {30'd0, bus.rd_valid}, 32'd1);
        chk("post_rst_rd_data", bus.rd_data, 32'ha1a1a1a1);

`ifdef BLOCKMEM_ARB_STATS_EN
        // 6. saturating read conflict counter and clear
        chk("wr_conf_one", {16'd0, wr_conflicts}, 32'd1);
        bus.rd_req = 2'b11;
        repeat (70000) @(posedge clk);
        #1;
        chk("rd_conf_sat", {16'd0, rd_conflicts}, 32'h0000ffff);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        bus.rd_req = 2'b00;
        chk("rd_conf_clr", {16'd0, rd_conflicts}, 32'd0);
        chk("wr_conf_clr", {16'd0, wr_conflicts}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
